// File: rtl/knn_pkg.sv
// Shared constants, state encoding and width helper for the k-NN result reader.
package knn_pkg;

  localparam int unsigned KNN_W       = 32;
  localparam int unsigned KNN_HW_K    = 10;
  localparam int unsigned KNN_NLABELS = 8;
  localparam int unsigned KNN_LBL_W   = $clog2(KNN_NLABELS);
  localparam int unsigned KNN_BIN_W   = $clog2(KNN_HW_K + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEL    = 3'd1,
    ST_SEND   = 3'd2,
    ST_LOOKUP = 3'd3,
    ST_ACC    = 3'd4,
    ST_VOTE   = 3'd5,
    ST_FINISH = 3'd6
  } state_e;

  // Bits needed to hold a count in 0..n.
  function automatic int unsigned knn_cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/knn_result_reader_if.sv
// Index stream from the result reader to the CPU-facing FIFO logic.
interface knn_result_reader_if #(
  parameter int unsigned IDX_W = 16
);
  logic [IDX_W-1:0] idx_o;
  logic             idx_valid_o;
  logic             idx_ready_i;
  logic             idx_last_o;

  modport master (output idx_o, idx_valid_o, idx_last_o, input idx_ready_i);
  modport slave  (input idx_o, idx_valid_o, idx_last_o, output idx_ready_i);
endinterface

// File: rtl/knn_vote_hist.sv
// Label histogram with saturating increment, clear and a one-bin-per-cycle argmax scan.
module knn_vote_hist
  import knn_pkg::*;
#(
  parameter int unsigned NLABELS = KNN_NLABELS,
  parameter int unsigned LBL_W   = KNN_LBL_W,
  parameter int unsigned BIN_W   = KNN_BIN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             inc_i,
  input  logic [LBL_W-1:0] inc_lbl_i,
  input  logic             scan_i,
  input  logic [LBL_W-1:0] scan_idx_i,
  output logic [LBL_W-1:0] best_next_c
);

  logic [BIN_W-1:0] bin_q [NLABELS];
  logic [BIN_W-1:0] bin_d [NLABELS];
  logic [BIN_W-1:0] best_cnt_q, best_cnt_d;
  logic [LBL_W-1:0] best_lbl_q, best_lbl_d;

  // Strictly-greater replacement keeps the lowest label on ties.
  always_comb begin
    bin_d      = bin_q;
    best_cnt_d = best_cnt_q;
    best_lbl_d = best_lbl_q;
    if (clear_i) begin
      for (int unsigned i = 0; i < NLABELS; i++) bin_d[i] = '0;
    end else if (inc_i && (bin_q[inc_lbl_i] != {BIN_W{1'b1}})) begin
      bin_d[inc_lbl_i] = bin_q[inc_lbl_i] + BIN_W'(1);
    end
    if (scan_i && ((scan_idx_i == '0) || (bin_q[scan_idx_i] > best_cnt_q))) begin
      best_cnt_d = bin_q[scan_idx_i];
      best_lbl_d = scan_idx_i;
    end
  end

  assign best_next_c = best_lbl_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NLABELS; i++) bin_q[i] <= '0;
      best_cnt_q <= '0;
      best_lbl_q <= '0;
    end else begin
      bin_q      <= bin_d;
      best_cnt_q <= best_cnt_d;
      best_lbl_q <= best_lbl_d;
    end
  end

endmodule

// File: rtl/knn_result_reader.sv
// Walks the sorter ranks after DONE and streams the stored indices.
// Build option KNN_VOTE_EN adds label lookup and majority-vote classification.
module knn_result_reader
  import knn_pkg::*;
#(
  parameter  int unsigned W       = KNN_W,
  parameter  int unsigned HW_K    = KNN_HW_K,
  parameter  int unsigned NLABELS = KNN_NLABELS,
  localparam int unsigned IDX_W   = W / 2,
  localparam int unsigned LBL_W   = $clog2(NLABELS),
  localparam int unsigned R_W     = knn_cnt_w(HW_K)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] count_i,
  output logic [15:0]      sel_o,
  input  logic [IDX_W-1:0] idx_i,
  knn_result_reader_if.master idx_if,
  output logic             lbl_rd_o,
  output logic [IDX_W-1:0] lbl_addr_o,
  input  logic [LBL_W-1:0] lbl_data_i,
  output logic [LBL_W-1:0] class_o,
  output logic             class_valid_o,
  output logic             busy_o,
  output logic             done_o
);

  state_e           state_q, state_d;
  logic [R_W-1:0]   r_q, r_d;
  logic [R_W-1:0]   keff_q, keff_d, keff_c;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, last_q, busy_q, done_q;
  logic             is_last_c;

`ifdef KNN_VOTE_EN
  localparam int unsigned BIN_W = knn_cnt_w(HW_K);
  logic [LBL_W-1:0] vcnt_q, vcnt_d;
  logic [LBL_W-1:0] class_q, class_d, best_next_c;
  logic [IDX_W-1:0] lbl_addr_q;
  logic             lbl_rd_q, class_valid_q;
  logic             vote_last_c;
  assign vote_last_c = (vcnt_q == LBL_W'(NLABELS - 1));
`endif

  assign keff_c    = (32'(count_i) >= HW_K) ? R_W'(HW_K) : R_W'(count_i);
  assign is_last_c = (r_q == keff_q - R_W'(1));

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    keff_d  = keff_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          keff_d  = keff_c;
          r_d     = '0;
          state_d = (keff_c == '0) ? ST_FINISH : ST_SEL;
        end
      end
      ST_SEL: begin
        idx_d   = idx_i;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (idx_if.idx_ready_i) begin
`ifdef KNN_VOTE_EN
          state_d = ST_LOOKUP;
`else
          if (is_last_c) begin
            state_d = ST_FINISH;
          end else begin
            r_d     = r_q + R_W'(1);
            state_d = ST_SEL;
          end
`endif
        end
      end
`ifdef KNN_VOTE_EN
      ST_LOOKUP: state_d = ST_ACC;
      ST_ACC: begin
        if (is_last_c) begin
          state_d = ST_VOTE;
        end else begin
          r_d     = r_q + R_W'(1);
          state_d = ST_SEL;
        end
      end
      ST_VOTE: begin
        if (vote_last_c) state_d = ST_FINISH;
      end
`endif
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output registers are loaded from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      keff_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      keff_q  <= keff_d;
      idx_q   <= idx_d;
      valid_q <= (state_d == ST_SEND);
      last_q  <= (state_d == ST_SEND) && (r_d == keff_d - R_W'(1));
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_FINISH);
    end
  end

  assign sel_o              = 16'(r_q);
  assign idx_if.idx_o       = idx_q;
  assign idx_if.idx_valid_o = valid_q;
  assign idx_if.idx_last_o  = last_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;

`ifdef KNN_VOTE_EN
  always_comb begin
    vcnt_d  = (state_q == ST_VOTE) ? vcnt_q + LBL_W'(1) : '0;
    class_d = class_q;
    if (state_d == ST_FINISH) class_d = (state_q == ST_VOTE) ? best_next_c : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vcnt_q        <= '0;
      class_q       <= '0;
      lbl_rd_q      <= 1'b0;
      lbl_addr_q    <= '0;
      class_valid_q <= 1'b0;
    end else begin
      vcnt_q        <= vcnt_d;
      class_q       <= class_d;
      lbl_rd_q      <= (state_d == ST_LOOKUP);
      lbl_addr_q    <= (state_d == ST_LOOKUP) ? idx_q : '0;
      class_valid_q <= (state_d == ST_FINISH);
    end
  end

  knn_vote_hist #(
    .NLABELS (NLABELS),
    .LBL_W   (LBL_W),
    .BIN_W   (BIN_W)
  ) u_hist (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (state_q == ST_FINISH),
    .inc_i       (state_q == ST_ACC),
    .inc_lbl_i   (lbl_data_i),
    .scan_i      (state_q == ST_VOTE),
    .scan_idx_i  (vcnt_q),
    .best_next_c (best_next_c)
  );

  assign lbl_rd_o      = lbl_rd_q;
  assign lbl_addr_o    = lbl_addr_q;
  assign class_o       = class_q;
  assign class_valid_o = class_valid_q;
`else
  logic unused_lbl;
  assign unused_lbl    = ^lbl_data_i;
  assign lbl_rd_o      = 1'b0;
  assign lbl_addr_o    = '0;
  assign class_o       = '0;
  assign class_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_knn_result_reader.sv
// Randomized bench for knn_result_reader against a rank/histogram model (KNN_VOTE_EN aware).
module tb_knn_result_reader;
  localparam int HW_K    = 10;
  localparam int NLABELS = 8;

  logic        clk, rst, start;
  logic [15:0] count_i, sel_o, idx_i, lbl_addr_o;
  logic        lbl_rd_o, class_valid_o, busy_o, done_o;
  logic [2:0]  lbl_data_i, class_o;

  logic [15:0] sorter_mem [HW_K];
  logic [2:0]  lbl_map [64];
  int          cyc, checks, errors;

  knn_result_reader_if #(.IDX_W(16)) u_if ();

  knn_result_reader dut (
    .clk(clk), .rst(rst), .start(start), .count_i(count_i), .sel_o(sel_o),
    .idx_i(idx_i), .idx_if(u_if), .lbl_rd_o(lbl_rd_o), .lbl_addr_o(lbl_addr_o),
    .lbl_data_i(lbl_data_i), .class_o(class_o), .class_valid_o(class_valid_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Sorter selection port is combinational; label memory has one cycle of latency.
  assign idx_i = (sel_o < 16'(HW_K)) ? sorter_mem[sel_o[3:0]] : 16'hDEAD;
  always @(posedge clk) lbl_data_i <= lbl_rd_o ? lbl_map[lbl_addr_o[5:0]] : 3'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Majority label among the first keff ranks, lowest label wins ties.
  function automatic int exp_class(input int keff);
    int h[NLABELS];
    int best;
    for (int l = 0; l < NLABELS; l++) h[l] = 0;
    for (int i = 0; i < keff; i++) h[lbl_map[sorter_mem[i][5:0]]]++;
    best = 0;
    for (int l = 1; l < NLABELS; l++) if (h[l] > h[best]) best = l;
    return best;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < HW_K; i++) sorter_mem[i] = 16'($urandom_range(0, 63));
    for (int a = 0; a < 64; a++) lbl_map[a] = 3'($urandom_range(0, NLABELS - 1));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sel"}, sel_o, 0);
    chk({tag, "_idx"}, u_if.idx_o, 0);
    chk({tag, "_valid"}, u_if.idx_valid_o, 0);
    chk({tag, "_last"}, u_if.idx_last_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_lbl_rd"}, lbl_rd_o, 0);
    chk({tag, "_lbl_addr"}, lbl_addr_o, 0);
    chk({tag, "_class"}, class_o, 0);
    chk({tag, "_class_valid"}, class_valid_o, 0);
  endtask

  // mode: 0 ready held high, 1 random ready plus a mid-run start, 2 five-cycle stall on beat 2.
  task automatic run(input int cnt, input int mode, input int rst_beat, output int dcyc, output int cls);
    int keff, exp_done, beats, stalls, stall2, nrd, t0;
    bit prev_stall, done_seen, aborted, v, rdy;
    logic [15:0] p_idx, p_sel;
    logic p_last;
    keff = (cnt < HW_K) ? cnt : HW_K;
`ifdef KNN_VOTE_EN
    exp_done = (keff == 0) ? 1 : 4 * keff + NLABELS + 1;
`else
    exp_done = (keff == 0) ? 1 : 2 * keff + 1;
`endif
    beats = 0; stalls = 0; stall2 = 0; nrd = 0;
    prev_stall = 0; done_seen = 0; aborted = 0;
    p_idx = '0; p_sel = '0; p_last = 1'b0;
    dcyc = -1; cls = -1;
    @(negedge clk);
    start = 1'b1; count_i = 16'(cnt); t0 = cyc;
    for (int n = 0; n < 400 && !done_seen && !aborted; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (mode == 1 && n == 5 && keff >= 4) begin start = 1'b1; count_i = 16'd0; end
      v = u_if.idx_valid_o;
      case (mode)
        1:       rdy = ($urandom_range(0, 2) != 0);
        2:       rdy = !(v && beats == 2 && stall2 < 5);
        default: rdy = 1'b1;
      endcase
      if (rst_beat >= 0 && v && beats == rst_beat) begin rst = 1'b1; rdy = 1'b0; aborted = 1; end
      u_if.idx_ready_i = rdy;
      if (n == 0) chk("busy_after_start", busy_o, 1);
      if (prev_stall) begin
        chk("stall_valid", v, 1);
        chk("stall_idx", u_if.idx_o, p_idx);
        chk("stall_sel", sel_o, p_sel);
        chk("stall_last", u_if.idx_last_o, p_last);
      end
      if (v) begin
        chk("beat_in_range", beats < keff, 1);
        if (beats < keff) begin
          chk("beat_idx", u_if.idx_o, sorter_mem[beats]);
          chk("beat_last", u_if.idx_last_o, beats == keff - 1);
          chk("beat_sel", sel_o, beats);
        end
        chk("beat_busy", busy_o, 1);
      end
      if (busy_o && keff > 0) chk("sel_range", sel_o < 16'(keff), 1);
`ifdef KNN_VOTE_EN
      if (lbl_rd_o) begin
        nrd++;
        chk("lbl_rd_order", beats >= 1 && beats <= keff, 1);
        if (beats >= 1 && beats <= keff) chk("lbl_addr", lbl_addr_o, sorter_mem[beats - 1]);
      end
      if (class_valid_o && !done_o) chk("class_valid_stray", class_valid_o, 0);
`else
      chk("novote_lbl_rd", lbl_rd_o, 0);
      chk("novote_class", {class_valid_o, class_o}, 0);
`endif
      if (v && !rdy && !aborted) stalls++;
      if (mode == 2 && v && !rdy) stall2++;
      if (v && rdy) beats++;
      prev_stall = v && !rdy && !aborted;
      p_idx = u_if.idx_o; p_sel = sel_o; p_last = u_if.idx_last_o;
      if (done_o && !aborted) begin
        done_seen = 1;
        dcyc = cyc - t0;
        chk("done_cycle", dcyc, exp_done + stalls);
        chk("beat_count", beats, keff);
`ifdef KNN_VOTE_EN
        chk("class_valid", class_valid_o, 1);
        chk("class", class_o, exp_class(keff));
        chk("lbl_reads", nrd, keff);
`endif
        cls = int'(class_o);
      end
    end
    if (aborted) begin
      @(negedge clk);
      chk_all_zero("after_rst");
      rst = 1'b0;
      u_if.idx_ready_i = 1'b1;
    end else if (!done_seen) begin
      checks++; errors++;
      $display("FAIL timeout: no done_o for count %0d within 400 cycles", cnt);
    end else begin
      @(negedge clk);
      chk("done_pulse", done_o, 0);
      chk("busy_end", busy_o, 0);
      chk("class_valid_pulse", class_valid_o, 0);
`ifdef KNN_VOTE_EN
      chk("class_hold", class_o, exp_class(keff));
`endif
    end
  endtask

  int dc, cl;
  int tie_lbls [10] = '{2, 5, 2, 5, 1, 2, 5, 1, 2, 5};

  initial begin
    cyc = 0; checks = 0; errors = 0;
    rst = 1'b1; start = 1'b0; count_i = '0; u_if.idx_ready_i = 1'b1;
    fill_random();
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Ranks return 40..49 with a 4-4 tie between labels 2 and 5.
    for (int i = 0; i < HW_K; i++) begin
      sorter_mem[i] = 16'(40 + i);
      lbl_map[40 + i] = 3'(tie_lbls[i]);
    end
    run(25, 0, -1, dc, cl);
`ifdef KNN_VOTE_EN
    chk("pin_done_vote", dc, 49);
    chk("pin_class_tie", cl, 2);
`else
    chk("pin_done_novote", dc, 21);
`endif

    fill_random();
    run(3, 0, -1, dc, cl);
    run(10, 2, -1, dc, cl);
    run(0, 0, -1, dc, cl);
    chk("pin_done_empty", dc, 1);
`ifdef KNN_VOTE_EN
    chk("pin_class_empty", cl, 0);
`endif

    fill_random();
    run(10, 0, 4, dc, cl);
    run(10, 0, -1, dc, cl);

    for (int k = 0; k < 20; k++) begin
      fill_random();
      run($urandom_range(0, 14), 1, -1, dc, cl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
